// File: rtl/light_mon_pkg.sv
// Shared light encodings, direction/state enums and fault codes for the
// intersection conflict monitor.
package light_mon_pkg;

  localparam int NUM_DIR = 4;

  localparam logic [2:0] GREEN     = 3'b001;
  localparam logic [2:0] YELLOW    = 3'b010;
  localparam logic [2:0] RED       = 3'b100;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_S = 2'd1,
    DIR_E = 2'd2,
    DIR_W = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_ALLRED = 3'd3,
    ST_FAULT  = 3'd4
  } mon_state_e;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_ENCODING   = 3'd1;
  localparam logic [2:0] FC_CONFLICT   = 3'd2;
  localparam logic [2:0] FC_SEQUENCE   = 3'd3;
  localparam logic [2:0] FC_GREEN_DUR  = 3'd4;
  localparam logic [2:0] FC_YELLOW_DUR = 3'd5;
  localparam logic [2:0] FC_ALLRED     = 3'd6;

  function automatic logic legal_light(input logic [2:0] l);
    return (l == GREEN) || (l == YELLOW) || (l == RED);
  endfunction

endpackage

// File: rtl/light_flash_gen.sv
// Fault-mode flasher: RED for FLASH_CYC clocks, dark for FLASH_CYC clocks,
// starting on RED whenever restart is pulsed.
module light_flash_gen #(
  parameter int FLASH_CYC = 4
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       en,
  input  logic       restart,
  output logic [2:0] lamp
);
  import light_mon_pkg::*;

  localparam int FW = (FLASH_CYC > 1) ? $clog2(FLASH_CYC) : 1;
  localparam logic [FW-1:0] LAST = FW'(FLASH_CYC - 1);

  logic [FW-1:0] cnt_reg;
  logic          dark_reg;

  always_ff @(posedge clk) begin
    if (srst || restart) begin
      cnt_reg  <= '0;
      dark_reg <= 1'b0;
    end else if (en) begin
      if (cnt_reg == LAST) begin
        cnt_reg  <= '0;
        dark_reg <= ~dark_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign lamp = dark_reg ? LIGHT_OFF : RED;

endmodule

// File: rtl/light_conflict_monitor.sv
// Safety monitor for a fixed-time traffic controller: checks every light sample,
// re-drives it one clock later, and latches a fault with flashing red on violation.
module light_conflict_monitor #(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 4,
  parameter int ALLRED_MAX = 3,
  parameter int FLASH_CYC  = 4,
  parameter int CNT_W      = 5
) (
  input  logic       clk,
  input  logic       rst_a,
  input  logic [2:0] n_lights,
  input  logic [2:0] s_lights,
  input  logic [2:0] e_lights,
  input  logic [2:0] w_lights,
  input  logic       fault_clr,
  output logic [2:0] n_safe,
  output logic [2:0] s_safe,
  output logic [2:0] e_safe,
  output logic [2:0] w_safe,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] active_dir
);
  import light_mon_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] GREEN_LEN   = CNT_W'(GREEN_CYC);
  localparam logic [CNT_W-1:0] GREEN_OVER  = CNT_W'(GREEN_CYC + 1);
  localparam logic [CNT_W-1:0] YELLOW_LEN  = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] YELLOW_OVER = CNT_W'(YELLOW_CYC + 1);
  localparam logic [CNT_W-1:0] ALLRED_OVER = CNT_W'(ALLRED_MAX + 1);

  mon_state_e       state_reg, state_next;
  dir_e             dir_reg, dir_next, rise_dir, dir_plus;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [2:0]       code_reg, code_next;
  logic [2:0]       check_code, phase_code;

  logic [2:0] bus       [NUM_DIR];
  logic [2:0] prev_reg  [NUM_DIR];
  logic [2:0] pass_reg  [NUM_DIR];
  logic [2:0] pass_next [NUM_DIR];
  logic [2:0] safe_mux  [NUM_DIR];

  logic [NUM_DIR-1:0] is_green, non_red, illegal, rise;
  logic               any_nonred, multi_nonred, nxt_green;
  logic [2:0]         cur, flash_lamp;
  logic               flash_en, fault_entry;

  assign bus[0] = n_lights;
  assign bus[1] = s_lights;
  assign bus[2] = e_lights;
  assign bus[3] = w_lights;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIR; gi++) begin : g_bus
      assign is_green[gi] = (bus[gi] == GREEN);
      assign non_red[gi]  = (bus[gi] != RED);
      assign illegal[gi]  = !legal_light(bus[gi]);
      // A green counts as new only when the previous sample on that bus was not green.
      assign rise[gi]     = is_green[gi] && (prev_reg[gi] != GREEN);
    end
  endgenerate

  assign any_nonred   = |non_red;
  assign multi_nonred = (non_red & (non_red - 4'd1)) != 4'd0;
  assign dir_plus     = dir_e'(dir_reg + 2'd1);
  assign cur          = bus[dir_reg];
  assign nxt_green    = is_green[dir_plus];
  assign cnt_inc      = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_comb begin
    rise_dir = DIR_N;
    for (int i = NUM_DIR - 1; i >= 0; i--) begin
      if (rise[i]) rise_dir = dir_e'(i);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_reg <= ST_IDLE;
      dir_reg   <= DIR_N;
      cnt_reg   <= '0;
      code_reg  <= FC_NONE;
      for (int i = 0; i < NUM_DIR; i++) begin
        prev_reg[i] <= RED;
        pass_reg[i] <= RED;
      end
    end else begin
      state_reg <= state_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      code_reg  <= code_next;
      for (int i = 0; i < NUM_DIR; i++) begin
        prev_reg[i] <= bus[i];
        pass_reg[i] <= pass_next[i];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    code_next  = code_reg;
    check_code = FC_NONE;
    phase_code = FC_NONE;

    if (|illegal)          check_code = FC_ENCODING;
    else if (multi_nonred) check_code = FC_CONFLICT;

    case (state_reg)
      ST_IDLE: begin
        if (|rise) begin
          state_next = ST_GREEN;
          dir_next   = rise_dir;
          cnt_next   = CNT_ONE;
        end
      end
      ST_GREEN: begin
        if (cur == GREEN) begin
          cnt_next = cnt_inc;
          if (cnt_inc == GREEN_OVER) phase_code = FC_GREEN_DUR;
        end else if (cur == YELLOW) begin
          if (cnt_reg != GREEN_LEN) begin
            phase_code = FC_GREEN_DUR;
          end else begin
            state_next = ST_YELLOW;
            cnt_next   = CNT_ONE;
          end
        end else begin
          phase_code = FC_SEQUENCE;
        end
      end
      ST_YELLOW: begin
        if (cur == YELLOW) begin
          cnt_next = cnt_inc;
          if (cnt_inc == YELLOW_OVER) phase_code = FC_YELLOW_DUR;
        end else if (cur == GREEN) begin
          phase_code = FC_SEQUENCE;
        end else if (any_nonred && !nxt_green) begin
          phase_code = FC_SEQUENCE;
        end else if (cnt_reg != YELLOW_LEN) begin
          phase_code = FC_YELLOW_DUR;
        end else if (nxt_green) begin
          state_next = ST_GREEN;
          dir_next   = dir_plus;
          cnt_next   = CNT_ONE;
        end else begin
          state_next = ST_ALLRED;
          cnt_next   = CNT_ONE;
        end
      end
      ST_ALLRED: begin
        if (nxt_green) begin
          state_next = ST_GREEN;
          dir_next   = dir_plus;
          cnt_next   = CNT_ONE;
        end else if (any_nonred) begin
          phase_code = FC_SEQUENCE;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == ALLRED_OVER) phase_code = FC_ALLRED;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_next = ST_IDLE;
          code_next  = FC_NONE;
          cnt_next   = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Sample-level checks outrank the phase checks.
    if (state_reg != ST_FAULT) begin
      if (check_code != FC_NONE || phase_code != FC_NONE) begin
        state_next = ST_FAULT;
        code_next  = (check_code != FC_NONE) ? check_code : phase_code;
        dir_next   = dir_reg;
        cnt_next   = '0;
      end
    end
  end

  // Output logic
  always_comb begin
    fault_entry = (state_reg != ST_FAULT) && (state_next == ST_FAULT);
    flash_en    = (state_reg == ST_FAULT);
    for (int i = 0; i < NUM_DIR; i++) begin
      pass_next[i] = ((state_reg == ST_FAULT) || (state_next == ST_FAULT)) ? RED : bus[i];
      safe_mux[i]  = (state_reg == ST_FAULT) ? flash_lamp : pass_reg[i];
    end
  end

  light_flash_gen #(
    .FLASH_CYC (FLASH_CYC)
  ) u_flash (
    .clk     (clk),
    .srst    (rst_a),
    .en      (flash_en),
    .restart (fault_entry),
    .lamp    (flash_lamp)
  );

  assign n_safe     = safe_mux[0];
  assign s_safe     = safe_mux[1];
  assign e_safe     = safe_mux[2];
  assign w_safe     = safe_mux[3];
  assign fault      = (state_reg == ST_FAULT);
  assign fault_code = code_reg;
  assign active_dir = dir_reg;

endmodule

// File: tb/tb_light_conflict_monitor.sv
// Scoreboard bench for light_conflict_monitor: each driven sample pushes the
// expected outputs for the following clock, which are popped and compared.
module tb_light_conflict_monitor;

  localparam logic [2:0]  G    = 3'b001;
  localparam logic [2:0]  Y    = 3'b010;
  localparam logic [2:0]  R    = 3'b100;
  localparam logic [11:0] ALLR = {R, R, R, R};

  logic       clk = 1'b0;
  logic       rst_a, fault_clr;
  logic [2:0] n_lights, s_lights, e_lights, w_lights;
  logic [2:0] n_safe, s_safe, e_safe, w_safe;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] active_dir;

  typedef struct {
    logic [11:0] safe;
    logic        flt;
    logic [2:0]  code;
    logic [1:0]  dir;
    bit          chk_dir;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_txn    = 0;
  int   flash_i  = 0;

  light_conflict_monitor #(
    .GREEN_CYC (8), .YELLOW_CYC (4), .ALLRED_MAX (3), .FLASH_CYC (4), .CNT_W (5)
  ) dut (
    .clk        (clk),
    .rst_a      (rst_a),
    .n_lights   (n_lights),
    .s_lights   (s_lights),
    .e_lights   (e_lights),
    .w_lights   (w_lights),
    .fault_clr  (fault_clr),
    .n_safe     (n_safe),
    .s_safe     (s_safe),
    .e_safe     (e_safe),
    .w_safe     (w_safe),
    .fault      (fault),
    .fault_code (fault_code),
    .active_dir (active_dir)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (txn %0d): got %0h expected %0h", tag, n_txn, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [11:0] safe, input logic f, input logic [2:0] c,
                              input logic [1:0] d, input bit cd);
    exp_t r;
    r.safe = safe; r.flt = f; r.code = c; r.dir = d; r.chk_dir = cd;
    return r;
  endfunction

  function automatic logic [11:0] set_dir(input logic [11:0] lt, input int d, input logic [2:0] v);
    logic [11:0] r;
    r = lt;
    r[(3 - d) * 3 +: 3] = v;
    return r;
  endfunction

  function automatic logic [11:0] pat(input int d, input logic [2:0] v);
    return set_dir(ALLR, d, v);
  endfunction

  task automatic step(input logic [11:0] lt, input logic clr, input logic rst, input exp_t ex);
    exp_t        e;
    logic [11:0] safe_now;
    {n_lights, s_lights, e_lights, w_lights} = lt;
    fault_clr = clr;
    rst_a     = rst;
    sb_q.push_back(ex);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    safe_now = {n_safe, s_safe, e_safe, w_safe};
    n_txn++;
    $display("txn %0d in=%b clr=%0b rst=%0b -> safe=%b fault=%0b code=%0d dir=%0d",
             n_txn, lt, clr, rst, safe_now, fault, fault_code, active_dir);
    check_val("safe", 32'(safe_now), 32'(e.safe));
    check_val("fault", 32'(fault), 32'(e.flt));
    check_val("fault_code", 32'(fault_code), 32'(e.code));
    if (e.chk_dir) check_val("active_dir", 32'(active_dir), 32'(e.dir));
  endtask

  task automatic ok(input logic [11:0] lt, input logic [1:0] d);
    step(lt, 1'b0, 1'b0, mk(lt, 1'b0, 3'd0, d, 1'b1));
  endtask

  task automatic ok_nd(input logic [11:0] lt);
    step(lt, 1'b0, 1'b0, mk(lt, 1'b0, 3'd0, 2'd0, 1'b0));
  endtask

  task automatic do_reset();
    repeat (2) step(ALLR, 1'b0, 1'b1, mk(ALLR, 1'b0, 3'd0, 2'd0, 1'b1));
  endtask

  task automatic phase(input int d, input int g, input int y);
    repeat (g) ok(pat(d, G), 2'(d));
    repeat (y) ok(pat(d, Y), 2'(d));
  endtask

  task automatic bad(input logic [11:0] lt, input logic [2:0] c);
    step(lt, 1'b0, 1'b0, mk(ALLR, 1'b1, c, 2'd0, 1'b0));
    flash_i = 1;
  endtask

  task automatic flash(input int nc, input logic [2:0] c, input logic [11:0] lt);
    logic [2:0] lamp;
    repeat (nc) begin
      lamp = (((flash_i / 4) % 2) == 0) ? R : 3'b000;
      step(lt, 1'b0, 1'b0, mk({4{lamp}}, 1'b1, c, 2'd0, 1'b0));
      flash_i++;
    end
  endtask

  task automatic clr(input logic [11:0] lt);
    step(lt, 1'b1, 1'b0, mk(ALLR, 1'b0, 3'd0, 2'd0, 1'b0));
  endtask

  initial begin
    rst_a = 1'b1;
    fault_clr = 1'b0;
    {n_lights, s_lights, e_lights, w_lights} = ALLR;

    // Nominal: two full rounds, next green directly after yellow
    do_reset();
    repeat (2) for (int d = 0; d < 4; d++) phase(d, 8, 4);

    // Conflict during N green, then recovery with the N green still lit
    do_reset();
    ok(pat(0, G), 2'd0);
    ok(pat(0, G), 2'd0);
    bad(set_dir(pat(0, G), 2, G), 3'd2);
    flash(10, 3'd2, pat(2, G));
    clr(pat(0, G));
    repeat (3) ok_nd(pat(0, G));
    ok_nd(ALLR);
    phase(1, 8, 4);
    ok(ALLR, 2'd1);

    // Green too short
    do_reset();
    repeat (7) ok(pat(0, G), 2'd0);
    bad(pat(0, Y), 3'd4);
    flash(3, 3'd4, ALLR);
    clr(ALLR);
    ok_nd(ALLR);

    // Yellow too long
    do_reset();
    phase(0, 8, 4);
    bad(pat(0, Y), 3'd5);
    flash(2, 3'd5, ALLR);

    // Yellow to red with the wrong approach going green
    do_reset();
    phase(0, 8, 4);
    bad(pat(2, G), 3'd3);
    flash(2, 3'd3, ALLR);

    // Green straight to red
    do_reset();
    repeat (3) ok(pat(0, G), 2'd0);
    bad(ALLR, 3'd3);
    flash(2, 3'd3, ALLR);

    // Illegal encoding outranks conflict
    do_reset();
    bad(set_dir(pat(0, 3'b011), 1, G), 3'd1);
    flash(2, 3'd1, ALLR);

    // All-red gaps, W to N wrap, then all-red timeout
    do_reset();
    phase(2, 8, 4);
    phase(3, 8, 4);
    repeat (2) ok(ALLR, 2'd3);
    phase(0, 8, 4);
    phase(1, 8, 4);
    phase(2, 8, 4);
    phase(3, 8, 4);
    repeat (3) ok(ALLR, 2'd3);
    bad(ALLR, 3'd6);
    flash(5, 3'd6, ALLR);

    // Reset together with clear, then clear outside fault is ignored
    step(ALLR, 1'b1, 1'b1, mk(ALLR, 1'b0, 3'd0, 2'd0, 1'b1));
    ok(pat(1, G), 2'd1);
    step(pat(1, G), 1'b1, 1'b0, mk(pat(1, G), 1'b0, 3'd0, 2'd1, 1'b1));
    ok(pat(1, G), 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/light_conflict_monitor.md
# light_conflict_monitor

Safety monitor downstream of the fixed-time `traffic_control` controller. Watches the four 3-bit light buses every clock, checks encoding, mutual exclusion, N→S→E→W phase order and green/yellow durations, and re-drives the lights to the intersection one cycle later. On any violation it latches a fault code and forces all four approaches to flashing red until cleared.

## Interface
- `GREEN_CYC`, 8: required green duration per approach, in clocks.
- `YELLOW_CYC`, 4: required yellow duration per approach, in clocks.
- `ALLRED_MAX`, 3: maximum tolerated consecutive all-red cycles between phases.
- `FLASH_CYC`, 4: half-period of fault flashing, in clocks.
- `CNT_W`, 5: phase counter width; must hold max(GREEN_CYC, YELLOW_CYC, ALLRED_MAX)+1.

- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_a` in 1: reset, synchronous and active-high.
- `n_lights`, `s_lights`, `e_lights`, `w_lights` in 3 each: controller outputs; GREEN=001, YELLOW=010, RED=100.
- `fault_clr` in 1: one-cycle pulse; clears a latched fault.
- `n_safe`, `s_safe`, `e_safe`, `w_safe` out 3 each: registered lights to the intersection.
- `fault` out 1: high while in FAULT.
- `fault_code` out 3: 0 none, 1 illegal encoding, 2 conflict, 3 sequence, 4 green duration, 5 yellow duration, 6 all-red timeout.
- `active_dir` out 2: approach currently tracked; 0 N, 1 S, 2 E, 3 W.

## Operation
- Reset values: state IDLE; `fault`=0; `fault_code`=0; all `*_safe`=100; `active_dir`=0; counter 0; previous-sample register all 100.
- Checks against the current input sample, active in every state except FAULT:
  - Encoding: any bus not in {001, 010, 100} → code 1.
  - Conflict: more than one bus non-red → code 2.
- Priority when several faults occur in one cycle: 1 > 2 > 3 > 4/5/6.
- IDLE: runs the encoding and conflict checks only. On a green rising edge (current sample 001, previous sample not 001) on exactly one bus d → GREEN, `active_dir`=d, cnt=1. A green already in progress, such as one left over after `fault_clr`, is ignored.
- GREEN: while bus d=001, cnt++.
  - cnt reaching GREEN_CYC+1 → code 4.
  - d becomes 010: cnt≠GREEN_CYC → code 4; otherwise → YELLOW, cnt=1.
  - d becomes 100 → code 3.
- YELLOW: while d=010, cnt++.
  - cnt reaching YELLOW_CYC+1 → code 5.
  - d becomes 001 → code 3.
  - d becomes 100 with cnt≠YELLOW_CYC → code 5.
  - d becomes 100 with cnt=YELLOW_CYC: if (d+1) mod 4 goes 001 in the same sample → GREEN with the new d, cnt=1. If a different bus goes green → code 3. If all red → ALLRED, cnt=1.
- ALLRED: all red, cnt++.
  - cnt reaching ALLRED_MAX+1 → code 6.
  - Green on (d+1) mod 4 → GREEN, cnt=1.
  - Green on any other bus, or any yellow → code 3.
- Direction wraps W(3)→N(0).
- Counter saturates at 2^CNT_W−1.
- FAULT: `fault_code` is held. All `*_safe` show 100 for FLASH_CYC cycles, then 000 for FLASH_CYC cycles, repeating; the first FAULT cycle shows 100. The inputs are ignored.
- `fault_clr` in FAULT → IDLE, code 0. `fault_clr` outside FAULT has no effect. `rst_a` dominates `fault_clr`.

## Timing
- Pass-through latency 1: in non-FAULT states `*_safe` at cycle t+1 equal the inputs sampled at cycle t.
- Faults are detected combinationally on the sample at cycle t. `fault`, `fault_code` and the first 100 flash appear at t+1. A violating pattern never reaches `*_safe`.
- `fault_clr` sampled at t: at t+1, `fault`=0 and all `*_safe`=100. Pass-through resumes at t+2.
- `active_dir` updates in the same cycle as the state change.
- Reset mid-phase: state returns to IDLE on the next edge. The next green rising edge starts tracking.

## Structure
- Package `light_mon_pkg` holds:
  - Light constants GREEN/YELLOW/RED.
  - Direction enum N/S/E/W.
  - State enum IDLE/GREEN/YELLOW/ALLRED/FAULT.
  - Fault-code constants.
- Sub-module `light_flash_gen`: FLASH_CYC half-period toggler, enabled in FAULT and restarted on FAULT entry. Outputs RED or 000.
- Top level contains the FSM, phase counter, previous-sample register and output mux.

## Test plan
- Nominal: `rst_a` high 2 cycles; drive two full rounds of N/S/E/W, each 8 green + 4 yellow, next green immediately after yellow. Expect `fault`=0 throughout, `*_safe` equal to the inputs delayed 1 cycle, `active_dir` sequence 0,1,2,3,0.
- Conflict: during N green (cycle 3), drive E=001 for one cycle. Expect `fault`=1 and code 2 the next cycle; `*_safe` 100 for 4 cycles, then 000 for 4, and so on. E green never appears on `e_safe`.
- Durations: N green for 7 cycles then yellow → code 4. Separately, N yellow for 5 cycles → code 5 on the 5th-cycle sample.
- Sequence: N yellow→red with E green in the same cycle → code 3. Separately, N green→red with no yellow → code 3.
- Priority and all-red: N=011 together with S=001 → code 1. After W yellow, hold all red for 4 cycles (ALLRED_MAX=3) → code 6.
- Recovery: pulse `fault_clr` in FAULT → next cycle `fault`=0 with all 100, pass-through the cycle after; a green already in progress is ignored until its next rising edge. `fault_clr` together with `rst_a` → reset values.
